// File: rtl/seq_squarer.sv
// -----------------------------------------------------------------------------
// seq_squarer
//   Sequential shift-add squarer. It computes x_in * x_in for an unsigned
//   WIDTH-bit operand and processes one multiplier bit per clock. It is used
//   alongside the square-root datapath to check roots and to build radicands.
//
// Ports
//   clk     in   1        rising-edge clock
//   rst     in   1        asynchronous active-high reset
//   start   in   1        request pulse, sampled only while idle
//   x_in    in   WIDTH    operand, captured on the accepting edge
//   busy    out  1        high while computing and during the done cycle
//   done    out  1        one-cycle pulse; square holds the new result
//   square  out  2*WIDTH  last completed result
//
// Timing
//   Start is accepted at edge E0. Done is high after edge E_WIDTH and busy
//   falls after E_(WIDTH+1). A new start can be accepted at E_(WIDTH+2).
// -----------------------------------------------------------------------------
module seq_squarer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] square
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q,   state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [RW-1:0]   acc_q,     acc_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic [RW-1:0]   square_q,  square_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;

  // The operand doubles as the multiplicand, zero-extended to the result width.
  logic [RW-1:0] mcand;
  logic [RW-1:0] addend;
  logic [RW-1:0] sum;
  logic [RW-1:0] carry;

  assign mcand  = {{WIDTH{1'b0}}, operand_q};
  assign addend = operand_q[cnt_q] ? (mcand << cnt_q) : '0;

  // Explicit ripple-carry adder with carry-in 0. The carry out of the top bit
  // is not needed because the largest result, (2^WIDTH-1)^2, fits in RW bits.
  assign carry[0] = 1'b0;
  for (genvar gi = 0; gi < RW; gi++) begin : g_rca
    assign sum[gi] = acc_q[gi] ^ addend[gi] ^ carry[gi];
    if (gi < RW - 1) begin : g_carry
      assign carry[gi+1] = (acc_q[gi] & addend[gi]) |
                           (carry[gi] & (acc_q[gi] ^ addend[gi]));
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    square_d  = square_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          operand_d = x_in;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // The final partial product is added on this edge, so the adder
          // output (not acc_q) is the completed square.
          square_d = sum;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy is registered, so it follows the state being entered.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      operand_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      square_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      square_q  <= square_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign square = square_q;

endmodule

// File: doc/seq_squarer.md
Name: seq_squarer

Overview:
- Sequential shift-add squarer: computes x*x for an unsigned WIDTH-bit operand.
- Processes one multiplier bit per clock.
- Inverse companion to the square-root datapath. Used to check root results (root*root vs radicand) and to build radicand stimulus.
- Accumulation is a 2*WIDTH-bit ripple-carry add, carry-in 0.

Parameters:
- WIDTH, 8, operand width in bits. Result is 2*WIDTH bits. Legal range 2..16.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- x_in  input  WIDTH  unsigned operand; sampled on the accepting edge only
- busy  output  1  high while in CALC or DONE
- done  output  1  one-cycle pulse; square is valid
- square  output  2*WIDTH  result register

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, square=0, internal accumulator/operand/counter=0. Reset mid-operation aborts the computation; no done pulse is produced.
- States: IDLE, CALC, DONE. Registered outputs only.
- IDLE:
  - start=1 at an edge: latch x_in into operand register (zero-extended to 2*WIDTH as multiplicand); acc=0; cnt=0; go to CALC; busy=1 from that edge.
  - start=0: remain in IDLE.
- CALC, one iteration per edge:
  - If operand[cnt]=1: acc = acc + (multiplicand << cnt), computed mod 2^(2*WIDTH). Overflow cannot occur; max is (2^WIDTH-1)^2.
  - cnt increments.
  - On the edge processing cnt=WIDTH-1: square=final acc value, done=1, go to DONE.
- DONE: single cycle. Next edge: done=0, busy=0, go to IDLE.
- Latency: start accepted at edge E0 -> done=1 and square valid after edge E_WIDTH (WIDTH cycles). Next start can be accepted at edge E_(WIDTH+2). Throughput is one result per WIDTH+2 cycles.
- start is ignored in CALC and DONE. It is not queued, and x_in changes have no effect.
- square holds the last result until the next completion. It is not cleared on start and not updated during CALC.
- done is never high together with state=IDLE.
- x_in=0: still runs the full WIDTH cycles; square=0.
- start held high continuously: a new operation is accepted on every IDLE visit, i.e. one result per WIDTH+2 cycles.
- A start coincident with reset deassertion is not accepted. start is sampled from the first edge after rst=0.

Test Plan:
- WIDTH=8, reset then start with x_in=13 -> busy rises at E0; done=1 exactly after E8; square=169 (0x00A9); busy=0 after E9.
- x_in=255 -> square=65025 (0xFE01) at done; x_in=0 -> square=0 after the full 8 cycles; x_in=1 -> square=1.
- start pulsed with x_in=200 during CALC of an operation on x_in=16 -> square=256; only one done pulse; the 200 request is lost.
- Back-to-back with start held high, x_in=16 then 15 -> done pulses 10 cycles apart; square=256 then 225; square holds 256 during the second CALC.
- Assert rst at E4 of x_in=100 -> outputs all 0 immediately (asynchronous, before the next edge); no done pulse. After release, start with x_in=12 -> square=144.
- Exhaustive sweep of x_in 0..255 -> each square equals x_in*x_in; latency constant at 8 cycles.
